// File: rtl/udp_regs_pkg.sv
// Shared definitions for the UDP register transport.
// Holds the command/sub-command byte values that the receiver expects, the
// header length, and the transmitter FSM state encoding.
package udp_regs_pkg;

  localparam logic [7:0] REG_CMD         = 8'h01;
  localparam logic [7:0] SUBCMD_WRITE    = 8'h00;
  localparam logic [7:0] SUBCMD_READBACK = 8'h01;
  localparam int         HDR_LEN         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } tx_state_e;

endpackage

// File: rtl/udp_tx_regs_bytesel.sv
// Payload byte selector for udp_tx_regs.
// Picks snapshot byte (cnt - HDR_LEN), so register 0 comes out first and
// each register goes out little-endian. Purely combinational.
//   snap      : registered copy of the register bank
//   cnt       : byte index within the packet (header bytes included)
//   data_byte : selected payload byte, 0 when cnt is outside the payload
module udp_tx_regs_bytesel
  import udp_regs_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic [NUM_REGS*32-1:0] snap,
  input  logic [11:0]            cnt,
  output logic [7:0]             data_byte
);

  logic [11:0] ofs;

  assign ofs = cnt - 12'(HDR_LEN);

  always_comb begin
    data_byte = 8'h00;
    for (int k = 0; k < NUM_REGS*4; k++) begin
      if (ofs == 12'(k)) data_byte = snap[8*k +: 8];
    end
  end

endmodule

// File: rtl/udp_tx_regs.sv
// Serializes a bank of 32-bit registers into one UDP payload per start.
// Packet: REG_CMD, SUBCMD, REG_OFS, tag, then reg 0..NUM_REGS-1 little-endian.
// The tag is a per-packet sequence number when UDP_TX_REGS_SEQ_EN is
// defined, otherwise a constant 8'h00.
//   c       : clock
//   rst     : synchronous active-high reset
//   start   : send one packet (ignored unless idle)
//   regs    : register values, reg i at [32*i+31:32*i]
//   txd     : payload byte
//   txdv    : txd valid
//   txlast  : final byte of the packet
//   txready : downstream accepts a byte when txdv & txready
//   busy    : packet in progress
module udp_tx_regs
  import udp_regs_pkg::*;
#(
  parameter int         NUM_REGS = 4,
  parameter int         REG_OFS  = 0,
  parameter logic [7:0] SUBCMD   = SUBCMD_READBACK
) (
  input  logic                   c,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_REGS*32-1:0] regs,
  output logic [7:0]             txd,
  output logic                   txdv,
  output logic                   txlast,
  input  logic                   txready,
  output logic                   busy
);

  localparam logic [11:0] LAST      = 12'(HDR_LEN + 4*NUM_REGS - 1);
  localparam logic [7:0]  REG_OFS_B = 8'(REG_OFS);

  tx_state_e             state, state_n;
  logic [11:0]           cnt, cnt_n, cnt_inc;
  logic [NUM_REGS*32-1:0] snap, snap_n;
  logic [7:0]            txd_n, hdr_byte, data_byte, hdr_tag;
  logic                  txdv_n, txlast_n, busy_n;
  logic                  hs, pkt_done;

  assign hs       = txdv & txready;
  assign cnt_inc  = cnt + 12'd1;
  assign pkt_done = (state != IDLE) && hs && (cnt == LAST);

`ifdef UDP_TX_REGS_SEQ_EN
  logic [7:0] seq;

  always_ff @(posedge c) begin
    if (rst)           seq <= 8'h00;
    else if (pkt_done) seq <= seq + 8'h01;
  end

  assign hdr_tag = seq;
`else
  assign hdr_tag = 8'h00;
`endif

  // Byte data is looked up for the index that becomes current after the
  // handshake, so the output register always holds the byte on the wire.
  udp_tx_regs_bytesel #(.NUM_REGS(NUM_REGS)) u_bytesel (
    .snap      (snap),
    .cnt       (cnt_inc),
    .data_byte (data_byte)
  );

  always_comb begin
    case (cnt_inc[1:0])
      2'd0:    hdr_byte = REG_CMD;
      2'd1:    hdr_byte = SUBCMD;
      2'd2:    hdr_byte = REG_OFS_B;
      default: hdr_byte = hdr_tag;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      snap   <= '0;
      txd    <= 8'h00;
      txdv   <= 1'b0;
      txlast <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      snap   <= snap_n;
      txd    <= txd_n;
      txdv   <= txdv_n;
      txlast <= txlast_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    snap_n   = snap;
    txd_n    = txd;
    txdv_n   = txdv;
    txlast_n = txlast;
    busy_n   = busy;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = HDR;
          cnt_n    = '0;
          snap_n   = regs;
          txd_n    = REG_CMD;
          txdv_n   = 1'b1;
          txlast_n = 1'b0;
          busy_n   = 1'b1;
        end
      end
      HDR, DATA: begin
        if (pkt_done) begin
          // Drop straight to idle so a start next cycle is taken.
          state_n  = IDLE;
          cnt_n    = '0;
          txd_n    = 8'h00;
          txdv_n   = 1'b0;
          txlast_n = 1'b0;
          busy_n   = 1'b0;
        end else if (hs) begin
          cnt_n    = cnt_inc;
          txd_n    = (cnt_inc < 12'(HDR_LEN)) ? hdr_byte : data_byte;
          txlast_n = (cnt_inc == LAST);
          if (state == HDR && cnt == 12'(HDR_LEN - 1)) state_n = DATA;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_regs.sv
module tb_udp_tx_regs;
  import udp_regs_pkg::*;

`ifdef UDP_TX_REGS_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic        c = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, txready = 1'b1;
  logic        start1 = 1'b0, txready1 = 1'b1;
  logic [63:0] regs = {32'hDDCCBBAA, 32'h44332211};
  logic [31:0] regs1 = 32'hA1B2C3D4;
  logic [7:0]  txd, txd1;
  logic        txdv, txlast, busy, txdv1, txlast1, busy1;
  int          checks = 0, errors = 0;
  logic [7:0]  exp_seq = 8'h00;

  always #5 c = ~c;

  udp_tx_regs #(.NUM_REGS(2)) u_dut (
    .c(c), .rst(rst), .start(start), .regs(regs), .txd(txd), .txdv(txdv),
    .txlast(txlast), .txready(txready), .busy(busy)
  );

  udp_tx_regs #(.NUM_REGS(1), .REG_OFS(8'h12), .SUBCMD(SUBCMD_WRITE)) u_dut1 (
    .c(c), .rst(rst), .start(start1), .regs(regs1), .txd(txd1), .txdv(txdv1),
    .txlast(txlast1), .txready(txready1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: txready always 1; mode 1: txready toggles 1/0.
  // chg_at / rst_at: byte index at which regs are overwritten / reset fires (-1 = never).
  task automatic send_pkt(input int mode, input int chg_at, input int rst_at,
                          input int exp_cycles, input string tag);
    logic [7:0]  e [12];
    logic [63:0] r0;
    int idx, cyc;
    bit done;
    r0 = regs; idx = 0; cyc = 0; done = 1'b0;
    e[0] = 8'h01; e[1] = 8'h01; e[2] = 8'h00; e[3] = SEQ ? exp_seq : 8'h00;
    for (int i = 0; i < 8; i++) e[4+i] = r0[8*i +: 8];
    @(negedge c); start = 1'b1; txready = 1'b1;
    @(posedge c); #1; start = 1'b0;
    while (!done && cyc < 100) begin
      chk($sformatf("%s dv b%0d", tag, idx), {31'd0, txdv}, 32'd1);
      chk($sformatf("%s txd b%0d", tag, idx), {24'd0, txd}, {24'd0, e[idx]});
      chk($sformatf("%s last b%0d", tag, idx), {31'd0, txlast}, {31'd0, idx == 11});
      chk($sformatf("%s busy b%0d", tag, idx), {31'd0, busy}, 32'd1);
      @(negedge c);
      txready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (idx == chg_at) regs = '1;
      if (idx == rst_at) rst = 1'b1;
      @(posedge c); #1;
      cyc++;
      if (rst) begin
        chk({tag, " rst dv"}, {31'd0, txdv}, 32'd0);
        chk({tag, " rst last"}, {31'd0, txlast}, 32'd0);
        chk({tag, " rst busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " rst txd"}, {24'd0, txd}, 32'd0);
        rst = 1'b0;
        exp_seq = 8'h00;
        done = 1'b1;
      end else begin
        if (txready) idx++;
        if (idx == 12) begin
          chk({tag, " end dv"}, {31'd0, txdv}, 32'd0);
          chk({tag, " end busy"}, {31'd0, busy}, 32'd0);
          chk({tag, " end last"}, {31'd0, txlast}, 32'd0);
          chk({tag, " cycles"}, cyc, exp_cycles);
          exp_seq = exp_seq + 8'h01;
          done = 1'b1;
        end
      end
    end
    if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
    regs = r0;
    txready = 1'b1;
  endtask

  typedef struct {
    logic       st;
    logic       rdy;
    logic [7:0] d;
    logic       dv;
    logic       last;
    logic       bsy;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] b032 [12];
  logic [7:0] e1 [8];
  int         p, pk;

  initial begin
    b032 = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 12; i++) begin
      tbl[i].st = (i == 0); tbl[i].rdy = 1'b1; tbl[i].d = b032[i];
      tbl[i].dv = 1'b1; tbl[i].last = (i == 11); tbl[i].bsy = 1'b1;
    end
    tbl[12].st = 1'b0; tbl[12].rdy = 1'b1; tbl[12].d = 8'h00;
    tbl[12].dv = 1'b0; tbl[12].last = 1'b0; tbl[12].bsy = 1'b0;
    e1 = '{8'h01, 8'h00, 8'h12, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

    // reset state
    repeat (3) @(posedge c);
    #1;
    chk("rst txdv", {31'd0, txdv}, 32'd0);
    chk("rst txlast", {31'd0, txlast}, 32'd0);
    chk("rst txd", {24'd0, txd}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst txdv1", {31'd0, txdv1}, 32'd0);
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    @(negedge c); rst = 1'b0;

    // start held high, single-register instance: 8 bytes, 1 idle cycle, repeat
    @(negedge c); start1 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge c); #1;
      p = k % 9; pk = k / 9;
      chk($sformatf("b2b dv k%0d", k), {31'd0, txdv1}, {31'd0, p != 8});
      chk($sformatf("b2b busy k%0d", k), {31'd0, busy1}, {31'd0, p != 8});
      if (p != 8) begin
        chk($sformatf("b2b txd k%0d", k), {24'd0, txd1},
            (p == 3) ? (SEQ ? pk : 32'd0) : {24'd0, e1[p]});
        chk($sformatf("b2b last k%0d", k), {31'd0, txlast1}, {31'd0, p == 7});
      end
    end
    @(negedge c); start1 = 1'b0;
    repeat (10) @(posedge c);

    // basic packet, table-driven
    for (int i = 0; i < 13; i++) begin
      @(negedge c); start = tbl[i].st; txready = tbl[i].rdy;
      @(posedge c); #1;
      if (tbl[i].dv) chk($sformatf("tbl%0d txd", i), {24'd0, txd}, {24'd0, tbl[i].d});
      chk($sformatf("tbl%0d dv", i), {31'd0, txdv}, {31'd0, tbl[i].dv});
      chk($sformatf("tbl%0d last", i), {31'd0, txlast}, {31'd0, tbl[i].last});
      chk($sformatf("tbl%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
    end
    exp_seq = 8'h01;

    send_pkt(1, -1, -1, 23, "toggle");
    send_pkt(0, 5, -1, 12, "regchg");
    send_pkt(0, -1, 6, 0, "abort");
    send_pkt(0, -1, -1, 12, "after_rst");

`ifdef UDP_TX_REGS_SEQ_EN
    @(negedge c); rst = 1'b1;
    @(negedge c); rst = 1'b0;
    exp_seq = 8'h00;
    for (int n = 0; n < 257; n++) send_pkt(0, -1, -1, 12, $sformatf("seq%0d", n));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_regs.md
UDP_TX_REGS -- requirements
Module: udp_tx_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers serialized (legal 1..255).
REQ-002 SHALL have parameter REG_OFS, default 0, register offset placed in header byte 2.
REQ-003 SHALL have parameter SUBCMD, default 8'h01, header byte 1 value.
REQ-004 SHALL have port c  input  1  clock; the block has one clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  request to send one packet.
REQ-007 SHALL have port regs  input  NUM_REGS*32  register values; reg i occupies bits [32*i+31:32*i].
REQ-008 SHALL have port txd  output  8  payload byte.
REQ-009 SHALL have port txdv  output  1  txd valid.
REQ-010 SHALL have port txlast  output  1  marks final byte of packet.
REQ-011 SHALL have port txready  input  1  downstream accepts byte when txdv & txready.
REQ-012 SHALL have port busy  output  1  high from start acceptance until the final byte is accepted.

Function
REQ-013 SHALL use FSM states IDLE, HDR, DATA.
REQ-014 IDLE: start=1 SHALL snapshot regs, move to HDR, and assert txdv with byte 0 on the next cycle (latency 1).
REQ-015 start while not IDLE SHALL be ignored and not queued.
REQ-016 Packet SHALL be 4+4*NUM_REGS bytes: byte0=8'h01, byte1=SUBCMD, byte2=REG_OFS[7:0], byte3=header tag (REQ-028/029).
REQ-017 DATA bytes SHALL be reg 0 first; each reg little-endian, so byte 4+4*i+j = snapshot[32*i+8*j+7:32*i+8*j].
REQ-018 SHALL use a 12-bit byte counter, reset to 0 at start acceptance, that increments only on handshake (txdv & txready).
REQ-019 HDR SHALL go to DATA after the handshake of byte 3; DATA SHALL go to IDLE after the handshake of byte 3+4*NUM_REGS.
REQ-020 txd, txdv and txlast SHALL be registered and held stable while txready=0.
REQ-021 txlast SHALL be high only together with txdv on the final byte.
REQ-022 txdv SHALL stay high continuously from byte 0 to the final handshake; there are no bubbles.
REQ-023 busy and txdv SHALL be low in the cycle after the final handshake; start in that cycle is accepted.
REQ-024 Changes on regs after the snapshot SHALL NOT affect the packet in flight.
REQ-025 The output byte stream SHALL be accepted unchanged by the existing register receiver (cmd 8'h01, 32-bit aligned length).

Reset
REQ-026 rst=1 SHALL force the following at the next edge, including mid-packet: IDLE, txdv=0, txlast=0, txd=0, busy=0, counter=0, snapshot=0, sequence=0.
REQ-027 A packet aborted by reset SHALL NOT be resumed, and its txlast is never emitted.

Configuration
REQ-028 With UDP_TX_REGS_SEQ_EN defined: byte3 SHALL be an 8-bit sequence number, 0 after reset, incremented after each completed packet, wrapping 255->0.
REQ-029 Without UDP_TX_REGS_SEQ_EN: byte3 SHALL be 8'h00 and no sequence register SHALL exist.

Structure
REQ-030 Package udp_regs_pkg SHALL hold REG_CMD=8'h01, SUBCMD_WRITE=8'h00, SUBCMD_READBACK=8'h01, HDR_LEN=4, and the FSM state enum.
REQ-031 Sub-module udp_tx_regs_bytesel SHALL select snapshot byte (counter-4) combinationally; the FSM and output registers stay in the top module.

Verification
REQ-032 NUM_REGS=2, regs={32'hDDCCBBAA,32'h44332211}, txready=1, start pulse -> 12 bytes 01 01 00 00 11 22 33 44 AA BB CC DD, txlast on byte 12, busy for 12 cycles.
REQ-033 Same stimulus, txready toggling 1/0 each cycle -> identical byte sequence, txd held during txready=0, 23 cycles to completion.
REQ-034 start held high for 30 cycles, NUM_REGS=1 -> back-to-back 8-byte packets, no extra packet in the start cycle of a busy packet, txdv low 1 cycle between packets.
REQ-035 regs changed to 32'hFFFFFFFF at byte 5 -> packet still carries the snapshot values.
REQ-036 rst asserted at byte 6 -> txdv=0 next cycle, no txlast; next start emits a full packet from byte 0.
REQ-037 UDP_TX_REGS_SEQ_EN, 257 packets -> byte3 values 00,01,...,FF,00.
